video_frame_fetch: RTL and testbench

- Sits directly downstream of video_signal_generate. Consumes its VSYNC/HSYNC timing and turns the active video window into read requests on a frame store.
- Frame store: 2448x2048, 12-bit pixels, raster order.
- Returned data is emitted as a pixel stream with SOF/EOL/EOF sideband, ready for the capture/dump stages.
- Also checks the incoming timing against the expected geometry and flags mismatches.

---
 rtl/video_pkg.sv | 14 +
 rtl/video_sideband_delay.sv | 32 +++
 rtl/video_frame_fetch.sv | 113 +++++++++++
 tb/tb_video_frame_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: default frame-store geometry and the fetch FSM encoding shared by the fetch block.
package video_pkg;
    localparam int H_ACT_DEF = 2448;
    localparam int V_ACT_DEF = 2048;
    localparam int DW_DEF    = 12;
    localparam int AW_DEF    = 23;
    localparam int SB_W      = 4;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        FLUSH   = 2'd3
    } state_t;
endpackage

// File: rtl/video_sideband_delay.sv
// video_sideband_delay: LAT-deep shift register carrying {valid, sof, eol, eof} alongside the read data.
module video_sideband_delay
    import video_pkg::*;
#(
    parameter int LAT = 1,
    parameter int W   = SB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         nxt_valid
);
    logic [W-1:0] sr [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
    end
    assign dout = sr[LAT-1];
    // valid bit about to enter the output stage, used to time the data capture
    generate
        if (LAT == 1) begin : g_one
            assign nxt_valid = din[W-1];
        end else begin : g_deep
            assign nxt_valid = sr[LAT-2][W-1];
        end
    endgenerate
endmodule

// File: rtl/video_frame_fetch.sv
// video_frame_fetch: turns the VSYNC/HSYNC active window into frame-store reads and a pixel
// stream with SOF/EOL/EOF, checking line length and line count against the expected geometry.
module video_frame_fetch
    import video_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          VSYNC,
    input  logic          HSYNC,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic          frame_done,
    output logic          line_err,
    output logic          frame_err
);
    localparam int XW = $clog2(H_ACT + 1);
    localparam int YW = $clog2(V_ACT + 1);
    localparam logic [XW-1:0] XMAX = XW'(H_ACT);
    localparam logic [YW-1:0] YMAX = YW'(V_ACT);
    state_t state, state_nxt;
    logic vs_d, hs_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y, y_nxt;
    logic [AW-1:0] base;
    logic [1:0] fl_cnt;
    logic vs_rise, vs_fall, hs_fall, active, rd_issue, start, fl_last;
    logic rd_sof, rd_eol, rd_eof, sb_nxt_valid;
    logic [SB_W-1:0] sb_out;
    assign vs_rise  = VSYNC & ~vs_d;
    assign vs_fall  = ~VSYNC & vs_d;
    assign hs_fall  = ~HSYNC & hs_d;
    assign active   = state == ACTIVE;
    assign start    = (state == WAIT_VS) & vs_rise & enable;
    assign fl_last  = fl_cnt == 2'(RD_LAT - 1);
    assign rd_issue = active & HSYNC & (x < XMAX) & (y < YMAX);
    // line end is folded into y before the frame check so a coincident HSYNC/VSYNC fall counts the line
    assign y_nxt    = hs_fall & (y < YMAX) ? y + YW'(1) : y;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = WAIT_VS;
            WAIT_VS: if (start) state_nxt = ACTIVE;
            ACTIVE:  if (vs_fall) state_nxt = FLUSH;
            FLUSH:   if (fl_last) state_nxt = WAIT_VS;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vs_d       <= 1'b0;
            hs_d       <= 1'b0;
            x          <= '0;
            y          <= '0;
            base       <= '0;
            fl_cnt     <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_sof     <= 1'b0;
            rd_eol     <= 1'b0;
            rd_eof     <= 1'b0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            vs_d       <= VSYNC;
            hs_d       <= HSYNC;
            rd_en      <= rd_issue;
            rd_sof     <= rd_issue & (x == '0) & (y == '0);
            rd_eol     <= rd_issue & (x == XW'(H_ACT - 1));
            rd_eof     <= rd_issue & (x == XW'(H_ACT - 1)) & (y == YW'(V_ACT - 1));
            if (rd_issue) rd_addr <= base + AW'(x);
            pix_data   <= sb_nxt_valid ? rd_data : '0;
            frame_done <= (state == FLUSH) & fl_last;
            fl_cnt     <= state == FLUSH ? fl_cnt + 2'd1 : '0;
            if (start) begin
                x         <= '0;
                y         <= '0;
                base      <= '0;
                line_err  <= 1'b0;
                frame_err <= 1'b0;
            end else if (active) begin
                x <= hs_fall ? '0 : rd_issue ? x + XW'(1) : x;
                y <= y_nxt;
                if (hs_fall & (y < YMAX)) base <= base + AW'(H_ACT);
                if ((HSYNC & (x >= XMAX)) | (hs_fall & (x != XMAX))) line_err <= 1'b1;
                if ((HSYNC & (y >= YMAX)) | (vs_fall & (y_nxt != YMAX))) frame_err <= 1'b1;
            end
        end
    end
    video_sideband_delay #(.LAT(RD_LAT), .W(SB_W)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .din       ({rd_en, rd_sof, rd_eol, rd_eof}),
        .dout      (sb_out),
        .nxt_valid (sb_nxt_valid)
    );
    assign {pix_valid, pix_sof, pix_eol, pix_eof} = sb_out;
endmodule

// File: tb/tb_video_frame_fetch.sv
// tb_video_frame_fetch: directed frames on an 8x4 geometry with a combinational frame store returning addr[11:0].
module tb_video_frame_fetch;
    localparam int H = 8;
    localparam int V = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic VSYNC = 1'b0;
    logic HSYNC = 1'b0;
    logic rd_en, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, line_err, frame_err;
    logic [22:0] rd_addr;
    logic [11:0] rd_data, pix_data;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_q[$];
    logic [14:0] px_q[$];
    int pv_first, hs_first, done_n, done_cyc, vs_fall_cyc;

    video_frame_fetch #(.H_ACT(H), .V_ACT(V), .DW(12), .AW(23), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_eof(pix_eof), .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rd_data = rd_en ? rd_addr[11:0] : 12'hfff;

    always @(negedge clk) begin
        if (rd_en) rd_q.push_back(int'(rd_addr));
        if (pix_valid) begin
            if (pv_first < 0) pv_first = cyc;
            px_q.push_back({pix_eof, pix_eol, pix_sof, pix_data});
        end
        if (frame_done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        px_q.delete();
        pv_first = -1;
        hs_first = -1;
        done_n = 0;
        done_cyc = -1;
        vs_fall_cyc = -1;
    endtask

    task automatic tick(input logic v, input logic h);
        if (h && hs_first < 0) hs_first = cyc;
        if (!v && VSYNC) vs_fall_cyc = cyc;
        VSYNC = v;
        HSYNC = h;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int n);
        repeat (n) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
    endtask

    task automatic vs_start();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic vs_end();
        repeat (5) tick(1'b0, 1'b0);
    endtask

    task automatic frame(input int nl, input int ll, input int ln);
        vs_start();
        for (int l = 0; l < nl; l++) line(l == ll ? ln : H);
        vs_end();
    endtask

    task automatic chk_addrs(input string tag);
        chk({tag, "_rd_count"}, 64'(rd_q.size()), 64'(H * V));
        for (int i = 0; i < rd_q.size() && i < H * V; i++) chk({tag, "_rd_addr"}, 64'(rd_q[i]), 64'(i));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, line_err, frame_err}, 64'd0);
    endtask

    initial begin
        clear_logs();
        repeat (3) tick(1'b0, 1'b0);
        chk_outs_zero("reset_outs");
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) tick(1'b0, 1'b0);

        // nominal frame
        clear_logs();
        frame(V, -1, H);
        chk_addrs("nom");
        chk("nom_pix_count", 64'(px_q.size()), 64'(H * V));
        for (int i = 0; i < px_q.size() && i < H * V; i++)
            chk("nom_pix", 64'(px_q[i]), 64'({(i == H * V - 1), (i % H == H - 1), (i == 0), 12'(i)}));
        chk("nom_pix_latency", 64'(pv_first - hs_first), 64'd2);
        chk("nom_done_count", 64'(done_n), 64'd1);
        chk("nom_done_latency", 64'(done_cyc - vs_fall_cyc), 64'd2);
        chk("nom_errs", {line_err, frame_err}, 64'd0);

        // long line 1
        clear_logs();
        frame(V, 1, 10);
        chk_addrs("long");
        chk("long_line_err", 64'(line_err), 64'd1);
        chk("long_frame_err", 64'(frame_err), 64'd0);
        chk("long_done_count", 64'(done_n), 64'd1);

        // short frame, then nominal frame clears flags
        clear_logs();
        frame(3, -1, H);
        chk("short_rd_count", 64'(rd_q.size()), 64'd24);
        chk("short_frame_err", 64'(frame_err), 64'd1);
        chk("short_done_count", 64'(done_n), 64'd1);
        clear_logs();
        vs_start();
        chk("restart_errs_clear", {line_err, frame_err}, 64'd0);
        for (int l = 0; l < V; l++) line(H);
        vs_end();
        chk_addrs("after_short");
        chk("after_short_errs", {line_err, frame_err}, 64'd0);
        chk("after_short_done", 64'(done_n), 64'd1);

        // five lines
        clear_logs();
        frame(5, -1, H);
        chk_addrs("five");
        chk("five_frame_err", 64'(frame_err), 64'd1);
        chk("five_pix_count", 64'(px_q.size()), 64'(H * V));
        if (px_q.size() == H * V) chk("five_last_pix", 64'(px_q[H * V - 1]), 64'({1'b1, 1'b1, 1'b0, 12'd31}));
        else chk("five_last_pix_present", 64'(px_q.size()), 64'(H * V));

        // VSYNC already high at reset release
        rst = 1'b1;
        repeat (3) tick(1'b1, 1'b0);
        rst = 1'b0;
        clear_logs();
        tick(1'b1, 1'b0);
        for (int l = 0; l < V; l++) line(H);
        vs_end();
        chk("vs_high_rd_count", 64'(rd_q.size()), 64'd0);
        chk("vs_high_done", 64'(done_n), 64'd0);
        clear_logs();
        frame(V, -1, H);
        chk_addrs("vs_high_next");

        // enable low at VSYNC rise
        enable = 1'b0;
        clear_logs();
        frame(V, -1, H);
        chk("dis_rd_count", 64'(rd_q.size()), 64'd0);
        chk("dis_done", 64'(done_n), 64'd0);
        enable = 1'b1;

        // reset mid-line 2
        clear_logs();
        vs_start();
        line(H);
        line(H);
        repeat (4) tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        rst = 1'b0;
        chk_outs_zero("midrst_outs");
        clear_logs();
        repeat (3) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        line(H);
        vs_end();
        chk("midrst_rd_count", 64'(rd_q.size()), 64'd0);
        chk("midrst_done", 64'(done_n), 64'd0);
        clear_logs();
        frame(V, -1, H);
        chk_addrs("midrst_next");
        chk("midrst_next_done", 64'(done_n), 64'd1);
        chk("midrst_next_errs", {line_err, frame_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
